// File: rtl/mapas_pkg.sv
// mapas_pkg: cell codes, headings, FSM states and ray helpers
// shared by the occupancy-grid builder and its step calculator.
package mapas_pkg;

    typedef enum logic [1:0] {
        DESCONHECIDA = 2'd0,
        LIVRE        = 2'd1,
        OCUPADA      = 2'd2,
        VISITADA     = 2'd3
    } celula_t;

    // 0=+Y, 1=+X, 2=-Y, 3=-X
    typedef enum logic [1:0] {
        NORTE = 2'd0,
        LESTE = 2'd1,
        SUL   = 2'd2,
        OESTE = 2'd3
    } direcao_t;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CAPTURA  = 2'd1,
        RAIO     = 2'd2,
        FINALIZA = 2'd3
    } estado_t;

    function automatic direcao_t rotaciona(input direcao_t d, input logic [1:0] delta);
        logic [1:0] r;
        r = d + delta;
        return direcao_t'(r);
    endfunction

    function automatic logic signed [1:0] dx(input direcao_t d);
        return (d == LESTE) ? 2'sb01 : (d == OESTE) ? 2'sb11 : 2'sb00;
    endfunction

    function automatic logic signed [1:0] dy(input direcao_t d);
        return (d == NORTE) ? 2'sb01 : (d == SUL) ? 2'sb11 : 2'sb00;
    endfunction

    // A free write only refines unknown/free cells; an occupied
    // write wins over everything except a visited cell.
    function automatic celula_t escreve(input celula_t atual, input celula_t novo);
        celula_t r;
        r = atual;
        if (novo == OCUPADA) begin
            if (atual != VISITADA) r = OCUPADA;
        end else if (novo == LIVRE) begin
            if (atual == DESCONHECIDA || atual == LIVRE) r = LIVRE;
        end
        return r;
    endfunction

endpackage

// File: rtl/mapas_passo.sv
// mapas_passo: cell reached after a given number of steps along a
// heading, with one extra sign bit so underflow is caught, not wrapped.
module mapas_passo
    import mapas_pkg::*;
#(
    parameter int TamanhoMalha     = 8,
    parameter int tamanhoDistancia = 4
) (
    input  logic [tamanhoDistancia-1:0]     baseX,
    input  logic [tamanhoDistancia-1:0]     baseY,
    input  logic [1:0]                      direcao,
    input  logic [tamanhoDistancia-1:0]     passo,
    output logic [$clog2(TamanhoMalha)-1:0] celulaX,
    output logic [$clog2(TamanhoMalha)-1:0] celulaY,
    output logic                            dentro
);

    localparam int W  = tamanhoDistancia + 1;
    localparam int IW = $clog2(TamanhoMalha);
    localparam logic [tamanhoDistancia:0] Limite = TamanhoMalha[tamanhoDistancia:0];

    logic signed [1:0]   ux;
    logic signed [1:0]   uy;
    logic signed [W-1:0] passoS;
    logic signed [W-1:0] somaX;
    logic signed [W-1:0] somaY;

    // base + passo * unit(heading), then bounds check on both axes
    always_comb begin
        ux     = dx(direcao_t'(direcao));
        uy     = dy(direcao_t'(direcao));
        passoS = $signed({1'b0, passo});
        somaX  = $signed({1'b0, baseX});
        somaY  = $signed({1'b0, baseY});
        if (ux == 2'sb01) somaX = somaX + passoS;
        else if (ux == 2'sb11) somaX = somaX - passoS;
        if (uy == 2'sb01) somaY = somaY + passoS;
        else if (uy == 2'sb11) somaY = somaY - passoS;
        dentro = !somaX[W-1] && ({1'b0, somaX[W-2:0]} < Limite)
              && !somaY[W-1] && ({1'b0, somaY[W-2:0]} < Limite);
        celulaX = somaX[IW-1:0];
        celulaY = somaY[IW-1:0];
    end

endmodule

// File: rtl/mapas_direcional.sv
// mapas_direcional: traces front/right/left rays into a 2-bit grid.
// MAPAS_VISITADO_EN marks the robot cell as visited instead of free.
module mapas_direcional
    import mapas_pkg::*;
#(
    parameter int TamanhoMalha     = 8,
    parameter int tamanhoDistancia = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [tamanhoDistancia-1:0] posicaoAtualnoEixoX,
    input  logic [tamanhoDistancia-1:0] posicaoAtualnoEixoY,
    input  logic [1:0]                  direcaoAtual,
    input  logic [tamanhoDistancia-1:0] distanciaFrente,
    input  logic [tamanhoDistancia-1:0] distanciaDireita,
    input  logic [tamanhoDistancia-1:0] distanciaEsquerda,
    input  logic                        novoDado,
    output logic                        pronto,
    output logic [TamanhoMalha-1:0][TamanhoMalha-1:0][1:0] malha,
    output logic                        operacaoFinalizada,
    output logic                        erroPosicao
);

    localparam int TD    = tamanhoDistancia;
    localparam int IW    = $clog2(TamanhoMalha);
    localparam int Ultima = TamanhoMalha - 1;
    localparam logic [IW-1:0] UltimaIdx = Ultima[IW-1:0];
    localparam logic [TD:0]   Limite    = TamanhoMalha[TD:0];
    localparam logic [TD-1:0] TodosUns  = '1;
    localparam logic [TD-1:0] Um        = {{(TD-1){1'b0}}, 1'b1};
`ifdef MAPAS_VISITADO_EN
    localparam celula_t CelulaRobo = VISITADA;
`else
    localparam celula_t CelulaRobo = LIVRE;
`endif

    estado_t       estado;
    logic [TD-1:0] xCap;
    logic [TD-1:0] yCap;
    direcao_t      dirCap;
    logic [TD-1:0] distF;
    logic [TD-1:0] distR;
    logic [TD-1:0] distL;
    logic [1:0]    sensor;
    logic [TD-1:0] passo;

    direcao_t         dirRaio;
    logic [TD-1:0]    distRaio;
    logic [IW-1:0]    ix;
    logic [IW-1:0]    iy;
    logic             dentro;
    logic signed [1:0] ux;
    logic signed [1:0] uy;
    logic             proximoFora;
    logic             fimRaio;
    logic             gravaRaio;
    celula_t          valorRaio;
    logic             foraMalha;

    mapas_passo #(
        .TamanhoMalha    (TamanhoMalha),
        .tamanhoDistancia(tamanhoDistancia)
    ) uPasso (
        .baseX  (xCap),
        .baseY  (yCap),
        .direcao(dirRaio),
        .passo  (passo),
        .celulaX(ix),
        .celulaY(iy),
        .dentro (dentro)
    );

    // heading and range of the sensor currently being traced
    always_comb begin
        dirRaio  = dirCap;
        distRaio = distF;
        unique case (sensor)
            2'd0: begin
                dirRaio  = dirCap;
                distRaio = distF;
            end
            2'd1: begin
                dirRaio  = rotaciona(dirCap, 2'd1);
                distRaio = distR;
            end
            default: begin
                dirRaio  = rotaciona(dirCap, 2'd3);
                distRaio = distL;
            end
        endcase
    end

    // end-of-ray detection looks one step ahead so each in-grid
    // step costs exactly one cycle
    always_comb begin
        ux = dx(dirRaio);
        uy = dy(dirRaio);
        proximoFora = (ux == 2'sb01 && ix == UltimaIdx)
                   || (ux == 2'sb11 && ix == '0)
                   || (uy == 2'sb01 && iy == UltimaIdx)
                   || (uy == 2'sb11 && iy == '0);
        fimRaio   = (distRaio == '0) || !dentro
                 || (passo == distRaio) || proximoFora;
        gravaRaio = (distRaio != '0) && dentro;
        valorRaio = (passo == distRaio && distRaio != TodosUns) ? OCUPADA : LIVRE;
        foraMalha = ({1'b0, xCap} >= Limite) || ({1'b0, yCap} >= Limite);
    end

    // control FSM, grid storage and registered status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            estado             <= OCIOSO;
            pronto             <= 1'b1;
            operacaoFinalizada <= 1'b0;
            erroPosicao        <= 1'b0;
            malha              <= '0;
            xCap               <= '0;
            yCap               <= '0;
            dirCap             <= NORTE;
            distF              <= '0;
            distR              <= '0;
            distL              <= '0;
            sensor             <= '0;
            passo              <= Um;
        end else begin
            operacaoFinalizada <= 1'b0;
            erroPosicao        <= 1'b0;
            unique case (estado)
                OCIOSO: begin
                    if (novoDado) begin
                        xCap   <= posicaoAtualnoEixoX;
                        yCap   <= posicaoAtualnoEixoY;
                        dirCap <= direcao_t'(direcaoAtual);
                        distF  <= distanciaFrente;
                        distR  <= distanciaDireita;
                        distL  <= distanciaEsquerda;
                        pronto <= 1'b0;
                        estado <= CAPTURA;
                    end
                end
                CAPTURA: begin
                    sensor <= 2'd0;
                    passo  <= Um;
                    if (foraMalha) begin
                        estado <= FINALIZA;
                    end else begin
                        malha[xCap[IW-1:0]][yCap[IW-1:0]] <= CelulaRobo;
                        estado <= RAIO;
                    end
                end
                RAIO: begin
                    if (gravaRaio)
                        malha[ix][iy] <= escreve(celula_t'(malha[ix][iy]), valorRaio);
                    if (fimRaio) begin
                        passo <= Um;
                        if (sensor == 2'd2) estado <= FINALIZA;
                        else sensor <= sensor + 2'd1;
                    end else begin
                        passo <= passo + Um;
                    end
                end
                FINALIZA: begin
                    operacaoFinalizada <= 1'b1;
                    erroPosicao        <= foraMalha;
                    pronto             <= 1'b1;
                    estado             <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mapas_direcional.sv
// tb_mapas_direcional: directed and random updates checked against
// a cell-by-cell ray model of the grid builder.
module tb_mapas_direcional;

    localparam int N    = 8;
    localparam int MAXD = 15;
`ifdef MAPAS_VISITADO_EN
    localparam int ROBO = 3;
`else
    localparam int ROBO = 1;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] posX, posY, dF, dR, dL;
    logic [1:0] dir;
    logic       novoDado;
    logic       pronto, operacaoFinalizada, erroPosicao;
    logic [N-1:0][N-1:0][1:0] malha;

    int checks = 0;
    int errors = 0;
    int mod[N][N];
    int DX[4] = '{0, 1, 0, -1};
    int DY[4] = '{1, 0, -1, 0};

    mapas_direcional #(
        .TamanhoMalha(N),
        .tamanhoDistancia(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .posicaoAtualnoEixoX(posX),
        .posicaoAtualnoEixoY(posY),
        .direcaoAtual(dir),
        .distanciaFrente(dF),
        .distanciaDireita(dR),
        .distanciaEsquerda(dL),
        .novoDado(novoDado),
        .pronto(pronto),
        .malha(malha),
        .operacaoFinalizada(operacaoFinalizada),
        .erroPosicao(erroPosicao)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic limpaModelo();
        for (int x = 0; x < N; x++)
            for (int y = 0; y < N; y++)
                mod[x][y] = 0;
    endtask

    task automatic modelo(input int x, y, h0, f, r, l,
                          output int ciclos, output bit erro);
        int dists[3];
        int rots[3];
        dists = '{f, r, l};
        rots  = '{0, 1, 3};
        erro   = (x >= N) || (y >= N);
        ciclos = 2;
        if (erro) return;
        mod[x][y] = ROBO;
        for (int k = 0; k < 3; k++) begin
            int h;
            int dentro;
            h = (h0 + rots[k]) % 4;
            dentro = 0;
            for (int s = 1; s <= dists[k]; s++) begin
                int cx;
                int cy;
                cx = x + s * DX[h];
                cy = y + s * DY[h];
                if (cx < 0 || cx >= N || cy < 0 || cy >= N) break;
                dentro++;
                if (s == dists[k] && dists[k] != MAXD) begin
                    if (mod[cx][cy] != 3) mod[cx][cy] = 2;
                end else if (mod[cx][cy] <= 1) begin
                    mod[cx][cy] = 1;
                end
            end
            ciclos += (dentro > 0) ? dentro : 1;
        end
    endtask

    function automatic int difGrade(output int fx, output int fy);
        int n;
        n = 0;
        fx = 0;
        fy = 0;
        for (int x = 0; x < N; x++)
            for (int y = 0; y < N; y++)
                if (malha[x][y] !== 2'(mod[x][y])) begin
                    if (n == 0) begin
                        fx = x;
                        fy = y;
                    end
                    n++;
                end
        return n;
    endfunction

    // Drive one sample, scramble the inputs after acceptance, wait for the pulse.
    task automatic aplica(input int x, y, h, f, r, l, input bit segura,
                          output int ciclos, output bit erroObs,
                          output bit pDur, output bit pFim);
        posX = 4'(x);
        posY = 4'(y);
        dir  = 2'(h);
        dF   = 4'(f);
        dR   = 4'(r);
        dL   = 4'(l);
        novoDado = 1'b1;
        @(posedge clock);
        #1;
        pDur = pronto;
        if (!segura) novoDado = 1'b0;
        posX = 4'($urandom);
        posY = 4'($urandom);
        dir  = 2'($urandom);
        dF   = 4'($urandom);
        dR   = 4'($urandom);
        dL   = 4'($urandom);
        ciclos  = -1;
        erroObs = 1'b0;
        pFim    = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clock);
            #1;
            if (operacaoFinalizada) begin
                ciclos  = n;
                erroObs = erroPosicao;
                pFim    = pronto;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int nd, fx, fy;
        reset = 1'b1;
        novoDado = 1'b0;
        {posX, posY, dF, dR, dL} = '0;
        dir = '0;
        repeat (2) @(posedge clock);
        #1;
        limpaModelo();
        checks++;
        if (pronto !== 1'b1) begin
            errors++;
            $display("FAIL reset_pronto got %b want 1", pronto);
        end
        checks++;
        if (operacaoFinalizada !== 1'b0) begin
            errors++;
            $display("FAIL reset_fim got %b want 0", operacaoFinalizada);
        end
        checks++;
        if (erroPosicao !== 1'b0) begin
            errors++;
            $display("FAIL reset_erro got %b want 0", erroPosicao);
        end
        nd = difGrade(fx, fy);
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL reset_grade cell[%0d][%0d] got %0d want 0", fx, fy, malha[fx][fy]);
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_mapeamento();
        int tab[8][7];
        int fixo[9][4];
        int expC, obsC, nd, fx, fy;
        bit expE, obsE, pD, pF;
        // x, y, dir, F, R, L, expected cycles to the pulse
        tab = '{'{3, 0, 1, 1, 2, 1, 5}, '{0, 0, 0, 4, 0, 0, 8},
                '{2, 0, 0, 2, 0, 0, 6}, '{2, 0, 0, 4, 0, 0, 8},
                '{2, 0, 0, 1, 0, 0, 5}, '{5, 3, 3, 15, 0, 0, 9},
                '{7, 7, 0, 3, 2, 0, 5}, '{7, 6, 1, 0, 5, 0, 9}};
        // after update i, cell [x][y] must hold v
        fixo = '{'{0, 4, 0, 2}, '{0, 3, 1, 2}, '{0, 3, 0, ROBO},
                 '{1, 0, 4, 2}, '{1, 0, 2, 1}, '{3, 2, 2, 2},
                 '{4, 2, 1, 2}, '{5, 0, 3, 1}, '{5, 4, 3, 1}};
        for (int i = 0; i < 8; i++) begin
            modelo(tab[i][0], tab[i][1], tab[i][2], tab[i][3], tab[i][4], tab[i][5], expC, expE);
            aplica(tab[i][0], tab[i][1], tab[i][2], tab[i][3], tab[i][4], tab[i][5],
                   (i == 0), obsC, obsE, pD, pF);
            novoDado = 1'b0;
            checks++;
            if (obsC !== tab[i][6]) begin
                errors++;
                $display("FAIL mapa[%0d]_ciclos got %0d want %0d", i, obsC, tab[i][6]);
            end
            checks++;
            if (obsE !== 1'b0) begin
                errors++;
                $display("FAIL mapa[%0d]_erro got %b want 0", i, obsE);
            end
            checks++;
            if (pD !== 1'b0 || pF !== 1'b1) begin
                errors++;
                $display("FAIL mapa[%0d]_pronto got %b/%b want 0/1", i, pD, pF);
            end
            nd = difGrade(fx, fy);
            checks++;
            if (nd != 0) begin
                errors++;
                $display("FAIL mapa[%0d]_grade cell[%0d][%0d] got %0d want %0d", i, fx, fy, malha[fx][fy], mod[fx][fy]);
            end
            for (int j = 0; j < 9; j++)
                if (fixo[j][0] == i) begin
                    checks++;
                    if (malha[fixo[j][1]][fixo[j][2]] !== 2'(fixo[j][3])) begin
                        errors++;
                        $display("FAIL mapa[%0d]_celula[%0d][%0d] got %0d want %0d", i, fixo[j][1], fixo[j][2], malha[fixo[j][1]][fixo[j][2]], fixo[j][3]);
                    end
                end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_erro();
        int tab[3][6];
        int expC, obsC, nd, fx, fy;
        bit expE, obsE, pD, pF;
        tab = '{'{9, 1, 1, 3, 3, 3}, '{1, 8, 0, 2, 2, 2}, '{15, 15, 2, 1, 1, 1}};
        for (int i = 0; i < 3; i++) begin
            modelo(tab[i][0], tab[i][1], tab[i][2], tab[i][3], tab[i][4], tab[i][5], expC, expE);
            aplica(tab[i][0], tab[i][1], tab[i][2], tab[i][3], tab[i][4], tab[i][5],
                   1'b0, obsC, obsE, pD, pF);
            checks++;
            if (obsC !== 2) begin
                errors++;
                $display("FAIL erro[%0d]_ciclos got %0d want 2", i, obsC);
            end
            checks++;
            if (obsE !== 1'b1) begin
                errors++;
                $display("FAIL erro[%0d]_flag got %b want 1", i, obsE);
            end
            nd = difGrade(fx, fy);
            checks++;
            if (nd != 0) begin
                errors++;
                $display("FAIL erro[%0d]_grade cell[%0d][%0d] got %0d want %0d", i, fx, fy, malha[fx][fy], mod[fx][fy]);
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int tab[2][6];
        int expC, obsC, nd, fx, fy;
        bit expE, obsE, pD, pF;
        tab = '{'{4, 4, 2, 3, 2, 6}, '{1, 5, 3, 1, 15, 2}};
        for (int i = 0; i < 2; i++) begin
            modelo(tab[i][0], tab[i][1], tab[i][2], tab[i][3], tab[i][4], tab[i][5], expC, expE);
            aplica(tab[i][0], tab[i][1], tab[i][2], tab[i][3], tab[i][4], tab[i][5],
                   (i == 0), obsC, obsE, pD, pF);
            checks++;
            if (obsC !== expC) begin
                errors++;
                $display("FAIL b2b[%0d]_ciclos got %0d want %0d", i, obsC, expC);
            end
            checks++;
            if (pD !== 1'b0 || pF !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d]_pronto got %b/%b want 0/1", i, pD, pF);
            end
            nd = difGrade(fx, fy);
            checks++;
            if (nd != 0) begin
                errors++;
                $display("FAIL b2b[%0d]_grade cell[%0d][%0d] got %0d want %0d", i, fx, fy, malha[fx][fy], mod[fx][fy]);
            end
        end
        novoDado = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_aleatorio();
        int v[6];
        int expC, obsC, nd, fx, fy;
        bit expE, obsE, pD, pF;
        for (int i = 0; i < 40; i++) begin
            v[0] = $urandom_range(0, 9);
            v[1] = $urandom_range(0, 9);
            v[2] = $urandom_range(0, 3);
            for (int k = 3; k < 6; k++) v[k] = $urandom_range(0, 15);
            modelo(v[0], v[1], v[2], v[3], v[4], v[5], expC, expE);
            aplica(v[0], v[1], v[2], v[3], v[4], v[5], 1'b0, obsC, obsE, pD, pF);
            checks++;
            if (obsC !== expC || obsE !== expE) begin
                errors++;
                $display("FAIL rand[%0d]_ciclos_erro got %0d/%b want %0d/%b", i, obsC, obsE, expC, expE);
            end
            nd = difGrade(fx, fy);
            checks++;
            if (nd != 0) begin
                errors++;
                $display("FAIL rand[%0d]_grade cell[%0d][%0d] got %0d want %0d", i, fx, fy, malha[fx][fy], mod[fx][fy]);
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset_meio();
        int nd, fx, fy, pulsos;
        posX = 4'd0;
        posY = 4'd0;
        dir  = 2'd0;
        dF   = 4'd7;
        dR   = 4'd3;
        dL   = 4'd0;
        novoDado = 1'b1;
        @(posedge clock);
        #1;
        novoDado = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        limpaModelo();
        nd = difGrade(fx, fy);
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL rstmeio_grade cell[%0d][%0d] got %0d want 0", fx, fy, malha[fx][fy]);
        end
        checks++;
        if (pronto !== 1'b1) begin
            errors++;
            $display("FAIL rstmeio_pronto got %b want 1", pronto);
        end
        reset = 1'b0;
        pulsos = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clock);
            #1;
            if (operacaoFinalizada) pulsos++;
        end
        checks++;
        if (pulsos != 0) begin
            errors++;
            $display("FAIL rstmeio_pulso got %0d pulses want 0", pulsos);
        end
    endtask

    initial begin
        test_reset();
        test_mapeamento();
        test_erro();
        test_back_to_back();
        test_aleatorio();
        test_reset_meio();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
